bram_dot_product_ctrl: RTL and testbench

Sequencer that computes one neuron pre-activation: a signed dot product of an input vector and a weight vector.
- Each vector sits in its own dual_port_bram instance; this block drives Port B (read) of both.
- It absorbs the 1-cycle BRAM read latency, accumulates products, and reports the result through a start/done handshake.
- It sits between the top-level layer scheduler (or testbench) and the input/weight BRAMs. The BRAMs are loaded via Port A beforehand.

---
 rtl/nn_accel_pkg.sv | 22 ++
 rtl/mac_unit.sv | 55 +++++
 rtl/bram_dot_product_ctrl.sv | 168 ++++++++++++++++
 tb/tb_bram_dot_product_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_accel_pkg.sv
// Shared definitions for the neural-network accelerator blocks.
// Holds the sequencer state encoding, default datapath widths and the
// accumulator-width helper that the layer scheduler will also use.
package nn_accel_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Two full-width signed products plus one bit per address bit of growth;
  // this cannot overflow for any vector length up to 2^addr_w.
  function automatic int acc_width(input int data_w, input int addr_w);
    return 2 * data_w + addr_w;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Signed multiply-accumulate with synchronous clear and enable.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : clear accumulator at the next edge (wins over i_en)
//   i_en           : add i_a*i_b (signed) at the next edge
//   i_a, i_b       : two's-complement operands
//   o_acc_nxt      : value the accumulator takes at the next edge; lets the
//                    parent register a final result in the same edge as the
//                    last accumulate
module mac_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 22
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clr,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [ACC_WIDTH-1:0]  o_acc_nxt
);

  localparam int PW = 2 * DATA_WIDTH;

  logic [PW-1:0]        w_a_ext;
  logic [PW-1:0]        w_b_ext;
  logic [PW-1:0]        w_prod;
  logic [ACC_WIDTH-1:0] w_prod_ext;
  logic [ACC_WIDTH-1:0] r_acc;

  // The low PW bits of the product of sign-extended operands equal the
  // exact signed product, which always fits in PW bits.
  assign w_a_ext    = {{DATA_WIDTH{i_a[DATA_WIDTH-1]}}, i_a};
  assign w_b_ext    = {{DATA_WIDTH{i_b[DATA_WIDTH-1]}}, i_b};
  assign w_prod     = w_a_ext * w_b_ext;
  assign w_prod_ext = {{(ACC_WIDTH-PW){w_prod[PW-1]}}, w_prod};

  always_comb begin
    o_acc_nxt = r_acc;
    if (i_clr) begin
      o_acc_nxt = '0;
    end else if (i_en) begin
      o_acc_nxt = r_acc + w_prod_ext;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else begin
      r_acc <= o_acc_nxt;
    end
  end

endmodule

// File: rtl/bram_dot_product_ctrl.sv
// Dot-product sequencer: reads an input vector and a weight vector from two
// BRAMs through their read ports, accumulates the signed products and
// returns the (optionally ReLU-clamped) sum with a start/done handshake.
//
// state   | meaning
// --------+---------------------------------------------
// S_IDLE  | waiting for i_start
// S_READ  | issuing one read per cycle to both BRAMs
// S_DRAIN | last read data returning, final accumulate
// S_DONE  | o_done pulse, o_result valid
//
// Ports:
//   i_clk, i_rst_n                    : clock, async active-low reset
//   i_start, i_vec_len, i_in_base,
//   i_w_base, i_relu_en               : request, sampled in S_IDLE only
//   o_in_b_en/addr, i_in_b_dout       : input BRAM read port
//   o_w_b_en/addr, i_w_b_dout         : weight BRAM read port
//   o_busy, o_done, o_result          : status and result (all registered)
module bram_dot_product_ctrl
  import nn_accel_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, ADDR_WIDTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH:0]   i_vec_len,
  input  logic [ADDR_WIDTH-1:0] i_in_base,
  input  logic [ADDR_WIDTH-1:0] i_w_base,
  input  logic                  i_relu_en,
  output logic                  o_in_b_en,
  output logic [ADDR_WIDTH-1:0] o_in_b_addr,
  input  logic [DATA_WIDTH-1:0] i_in_b_dout,
  output logic                  o_w_b_en,
  output logic [ADDR_WIDTH-1:0] o_w_b_addr,
  input  logic [DATA_WIDTH-1:0] i_w_b_dout,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ACC_WIDTH-1:0]  o_result
);

  state_e                r_state, w_state_nxt;
  logic [ADDR_WIDTH:0]   r_len, w_len_nxt;
  logic [ADDR_WIDTH:0]   r_idx, w_idx_nxt;
  logic                  r_relu, w_relu_nxt;
  logic                  r_en, w_en_nxt;
  logic [ADDR_WIDTH-1:0] r_in_addr, w_in_addr_nxt;
  logic [ADDR_WIDTH-1:0] r_w_addr, w_w_addr_nxt;
  logic                  r_valid;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;
  logic [ACC_WIDTH-1:0]  r_result, w_result_nxt;
  logic                  w_acc_clr;
  logic [ACC_WIDTH-1:0]  w_acc_nxt;

  mac_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (w_acc_clr),
    .i_en      (r_valid),
    .i_a       (i_in_b_dout),
    .i_b       (i_w_b_dout),
    .o_acc_nxt (w_acc_nxt)
  );

  // r_idx counts reads already presented on the port (including the one
  // being issued this cycle), so READ ends when it reaches r_len.
  always_comb begin
    w_state_nxt   = r_state;
    w_len_nxt     = r_len;
    w_idx_nxt     = r_idx;
    w_relu_nxt    = r_relu;
    w_en_nxt      = 1'b0;
    w_in_addr_nxt = r_in_addr;
    w_w_addr_nxt  = r_w_addr;
    w_result_nxt  = r_result;
    w_acc_clr     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_len_nxt  = i_vec_len;
          w_relu_nxt = i_relu_en;
          w_acc_clr  = 1'b1;
          w_idx_nxt  = '0;
          if (i_vec_len != '0) begin
            w_state_nxt   = S_READ;
            w_en_nxt      = 1'b1;
            w_idx_nxt     = (ADDR_WIDTH+1)'(1);
            w_in_addr_nxt = i_in_base;
            w_w_addr_nxt  = i_w_base;
          end else begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_READ: begin
        if (r_idx == r_len) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_en_nxt      = 1'b1;
          w_idx_nxt     = r_idx + (ADDR_WIDTH+1)'(1);
          w_in_addr_nxt = r_in_addr + ADDR_WIDTH'(1);
          w_w_addr_nxt  = r_w_addr + ADDR_WIDTH'(1);
        end
      end
      S_DRAIN: begin
        w_state_nxt  = S_DONE;
        w_result_nxt = (r_relu && w_acc_nxt[ACC_WIDTH-1]) ? '0 : w_acc_nxt;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_len     <= '0;
      r_idx     <= '0;
      r_relu    <= 1'b0;
      r_en      <= 1'b0;
      r_in_addr <= '0;
      r_w_addr  <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
    end else begin
      r_len     <= w_len_nxt;
      r_idx     <= w_idx_nxt;
      r_relu    <= w_relu_nxt;
      r_en      <= w_en_nxt;
      r_in_addr <= w_in_addr_nxt;
      r_w_addr  <= w_w_addr_nxt;
      r_valid   <= r_en;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_result  <= w_result_nxt;
    end
  end

  assign o_in_b_en   = r_en;
  assign o_w_b_en    = r_en;
  assign o_in_b_addr = r_in_addr;
  assign o_w_b_addr  = r_w_addr;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_result    = r_result;

endmodule

// File: tb/tb_bram_dot_product_ctrl.sv
// Directed bench for bram_dot_product_ctrl with behavioural BRAM read ports.
// Each launch pushes the expected read addresses, result and done cycle into
// queues; negedge monitors pop and compare as the DUT produces them.
module tb_bram_dot_product_ctrl;

  localparam int DW = 8;
  localparam int AW = 6;
  localparam int RW = 2 * DW + AW;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW:0]   vec_len;
  logic [AW-1:0] in_base;
  logic [AW-1:0] w_base;
  logic          relu_en;
  logic          in_b_en;
  logic [AW-1:0] in_b_addr;
  logic [DW-1:0] in_b_dout;
  logic          w_b_en;
  logic [AW-1:0] w_b_addr;
  logic [DW-1:0] w_b_dout;
  logic          busy;
  logic          done;
  logic [RW-1:0] result;

  logic [DW-1:0] mem_in [64];
  logic [DW-1:0] mem_w  [64];

  int n_assert = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int cyc      = 0;

  logic [2*AW-1:0] q_addr [$];
  logic [RW-1:0]   q_res  [$];
  int              q_cyc  [$];

  bram_dot_product_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_vec_len   (vec_len),
    .i_in_base   (in_base),
    .i_w_base    (w_base),
    .i_relu_en   (relu_en),
    .o_in_b_en   (in_b_en),
    .o_in_b_addr (in_b_addr),
    .i_in_b_dout (in_b_dout),
    .o_w_b_en    (w_b_en),
    .o_w_b_addr  (w_b_addr),
    .i_w_b_dout  (w_b_dout),
    .o_busy      (busy),
    .o_done      (done),
    .o_result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    in_b_dout = '0;
    w_b_dout  = '0;
  end
  always @(posedge clk) begin
    if (in_b_en) in_b_dout <= mem_in[in_b_addr];
    if (w_b_en)  w_b_dout  <= mem_w[w_b_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_b_en || w_b_en) begin
        check("read_expected", 64'(q_addr.size() != 0), 64'd1);
        check("en_pair", {62'd0, in_b_en, w_b_en}, 64'd3);
        if (q_addr.size() != 0) begin
          logic [2*AW-1:0] ea;
          ea = q_addr.pop_front();
          check("in_addr", 64'(in_b_addr), 64'(ea[2*AW-1:AW]));
          check("w_addr", 64'(w_b_addr), 64'(ea[AW-1:0]));
        end
      end
      if (done) begin
        check("done_expected", 64'(q_res.size() != 0), 64'd1);
        check("reads_all_issued", 64'(q_addr.size()), 64'd0);
        check("busy_in_done", 64'(busy), 64'd1);
        if (q_res.size() != 0) begin
          logic [RW-1:0] er;
          int            ec;
          er = q_res.pop_front();
          ec = q_cyc.pop_front();
          check("result", 64'(result), 64'(er));
          check("done_cycle", 64'(cyc), 64'(ec));
        end
        n_done++;
      end
    end
  end

  // Drives one start in the current idle cycle and records expectations.
  task automatic launch(input int len, input int ib, input int wb, input bit relu);
    longint acc;
    @(negedge clk);
    #1;
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_done", 64'(done), 64'd0);
    acc = 0;
    for (int i = 0; i < len; i++) begin
      logic [AW-1:0] ai;
      logic [AW-1:0] aw;
      ai = AW'(ib + i);
      aw = AW'(wb + i);
      acc += longint'($signed(mem_in[ai])) * longint'($signed(mem_w[aw]));
      q_addr.push_back({ai, aw});
    end
    if (relu && acc < 0) acc = 0;
    q_res.push_back(RW'(acc));
    q_cyc.push_back(cyc + len + 2);
    start   = 1'b1;
    vec_len = (AW+1)'(len);
    in_base = AW'(ib);
    w_base  = AW'(wb);
    relu_en = relu;
    @(negedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input int budget);
    int n0;
    n0 = n_done;
    for (int i = 0; i < budget && n_done == n0; i++) begin
      @(negedge clk);
      #1;
    end
    check("done_within_budget", 64'(n_done != n0), 64'd1);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    vec_len = '0;
    in_base = '0;
    w_base  = '0;
    relu_en = 1'b0;
    for (int i = 0; i < 64; i++) begin
      mem_in[i] = '0;
      mem_w[i]  = '0;
    end
    #3;
    check("rst_in_en", 64'(in_b_en), 64'd0);
    check("rst_w_en", 64'(w_b_en), 64'd0);
    check("rst_in_addr", 64'(in_b_addr), 64'd0);
    check("rst_w_addr", 64'(w_b_addr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // basic: [1,2,3,4].[5,6,7,8] = 70
    for (int i = 0; i < 4; i++) begin
      mem_in[i] = DW'(i + 1);
      mem_w[i]  = DW'(i + 5);
    end
    launch(4, 0, 0, 1'b0);
    wait_done(20);
    check("basic_70", 64'(result), 64'd70);

    // signed and ReLU: [-3,2].[4,1] = -10
    mem_in[10] = 8'hFD;
    mem_in[11] = 8'h02;
    mem_w[20]  = 8'h04;
    mem_w[21]  = 8'h01;
    launch(2, 10, 20, 1'b0);
    wait_done(20);
    check("signed_m10", 64'(result), 64'h3FFFF6);
    launch(2, 10, 20, 1'b1);
    wait_done(20);
    check("relu_zero", 64'(result), 64'd0);

    // zero length
    launch(0, 5, 5, 1'b0);
    wait_done(10);
    check("len0_result", 64'(result), 64'd0);

    // start during READ must be ignored
    launch(4, 0, 0, 1'b0);
    start   = 1'b1;
    vec_len = (AW+1)'(1);
    in_base = AW'(10);
    w_base  = AW'(20);
    @(negedge clk);
    #1;
    start = 1'b0;
    wait_done(20);
    check("poke_result", 64'(result), 64'd70);
    repeat (3) begin
      @(negedge clk);
      #1;
      check("result_hold", 64'(result), 64'd70);
    end

    // back-to-back: second start in first idle cycle after done
    launch(2, 10, 20, 1'b0);
    wait_done(20);
    launch(4, 0, 0, 1'b0);
    wait_done(20);
    check("b2b_result", 64'(result), 64'd70);

    // extremes and address wrap
    for (int i = 0; i < 64; i++) begin
      mem_in[i] = 8'h80;
      mem_w[i]  = 8'h80;
    end
    launch(64, 60, 60, 1'b0);
    wait_done(100);
    check("extreme_result", 64'(result), 64'd1048576);

    // reset in the middle of READ
    launch(8, 0, 0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_en", 64'(in_b_en), 64'd0);
    check("midrst_w_en", 64'(w_b_en), 64'd0);
    check("midrst_in_addr", 64'(in_b_addr), 64'd0);
    check("midrst_w_addr", 64'(w_b_addr), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    q_addr.delete();
    q_res.delete();
    q_cyc.delete();
    repeat (3) begin
      @(negedge clk);
      check("rst_hold_done", 64'(done), 64'd0);
    end
    #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_no_done", 64'(done), 64'd0);
    end
    launch(1, 3, 7, 1'b0);
    wait_done(10);
    check("post_rst_len1", 64'(result), 64'd16384);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
